tlu_trigger_ctrl: RTL and testbench

Sequences trigger acceptance and DUT readout behind `tlu_handshake`. It takes decoded trigger events and trigger numbers from the handshake block, or internal software triggers. It launches one readout per accepted trigger and tags that readout with a 16-bit trigger number. It holds the DUT busy line until readout and dead time complete, and counts accepted and missed triggers for slow control.

---
 rtl/tlu_ctrl_pkg.sv | 17 +
 rtl/tlu_trigger_ctrl_sat_counter.sv | 38 +++
 rtl/tlu_trigger_ctrl.sv | 160 ++++++++++++++++
 tb/tb_tlu_trigger_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_ctrl_pkg.sv
// Shared types and constants for the TLU trigger controller.
package tlu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CNT = 3'd1,
    S_START    = 3'd2,
    S_READOUT  = 3'd3,
    S_DEAD     = 3'd4
  } state_t;

  localparam logic MODE_TLU = 1'b0;
  localparam logic MODE_INT = 1'b1;

  localparam logic [15:0] TAG_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/tlu_trigger_ctrl_sat_counter.sv
// Counter with synchronous clear, increment enable and
// selectable saturate-at-max or wrap-around behaviour.
module sat_counter #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (!SATURATE || (cnt_q != {WIDTH{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/tlu_trigger_ctrl.sv
// Trigger acceptance and readout sequencer behind tlu_handshake:
// one tagged readout per accepted trigger, busy held through dead time.
module tlu_trigger_ctrl
  import tlu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_TIMEOUT = 4096,
  parameter int unsigned RO_TIMEOUT  = 65535,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST_SYS,
  input  logic        ENABLE,
  input  logic        MODE,
  input  logic        TRIGGER_VALID,
  input  logic        TRIGGER_CNT_VALID,
  input  logic [15:0] TRIGGER_CNT,
  input  logic        INT_TRIG,
  input  logic        READOUT_DONE,
  input  logic        FIFO_PROG_FULL,
  output logic        DUT_BUSY,
  output logic        READOUT_START,
  output logic [15:0] TRIG_TAG,
  output logic        TAG_VALID,
  output logic [31:0] ACCEPT_CNT,
  output logic [15:0] MISS_CNT,
  output logic        CNT_TO_FLAG,
  output logic        RO_TO_FLAG
);

  localparam logic [15:0] CNT_LAST  = 16'(CNT_TIMEOUT - 1);
  localparam logic [15:0] RO_LAST   = 16'(RO_TIMEOUT - 1);
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] tag_q, tag_d;
  logic [15:0] itag_q, itag_d;
  logic        mode_q, mode_d;
  logic        tv_q, tv_d;
  logic        cnt_to_q, cnt_to_d;
  logic        ro_to_q, ro_to_d;

  logic        in_idle;
  logic        eff_mode;
  logic        trig;
  logic        accept;
  logic        miss;

  assign in_idle  = (state_q == S_IDLE);
  // MODE is only followed while idle; a running sequence keeps its mode.
  assign eff_mode = in_idle ? MODE : mode_q;
  assign trig     = (eff_mode == MODE_INT) ? INT_TRIG
                                           : (TRIGGER_VALID & ~tv_q);
  assign accept   = in_idle & trig & ENABLE & ~FIFO_PROG_FULL;
  assign miss     = trig & ~accept;

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    itag_d   = itag_q;
    mode_d   = eff_mode;
    tv_d     = TRIGGER_VALID;
    cnt_to_d = cnt_to_q;
    ro_to_d  = ro_to_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (eff_mode == MODE_INT) begin
            tag_d   = itag_q;
            state_d = S_START;
          end else begin
            state_d = S_WAIT_CNT;
          end
        end
      end
      S_WAIT_CNT: begin
        if (TRIGGER_CNT_VALID) begin
          tag_d   = TRIGGER_CNT;
          state_d = S_START;
        end else if (timer_q == CNT_LAST) begin
          cnt_to_d = 1'b1;
          tag_d    = TAG_TIMEOUT;
          state_d  = S_START;
        end
      end
      S_START: begin
        itag_d  = itag_q + 16'd1;
        state_d = S_READOUT;
      end
      S_READOUT: begin
        if (READOUT_DONE) begin
          state_d = S_DEAD;
        end else if (timer_q == RO_LAST) begin
          ro_to_d = 1'b1;
          state_d = S_DEAD;
        end
      end
      S_DEAD: begin
        if (timer_q == DEAD_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // One timer serves every state; restart it on each transition.
    timer_d = (state_d != state_q) ? 16'd0 : timer_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST_SYS) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      tag_q    <= '0;
      itag_q   <= '0;
      mode_q   <= MODE_TLU;
      tv_q     <= 1'b0;
      cnt_to_q <= 1'b0;
      ro_to_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      tag_q    <= tag_d;
      itag_q   <= itag_d;
      mode_q   <= mode_d;
      tv_q     <= tv_d;
      cnt_to_q <= cnt_to_d;
      ro_to_q  <= ro_to_d;
    end
  end

  sat_counter #(
    .WIDTH    (16),
    .SATURATE (1'b1)
  ) u_miss_cnt (
    .clk   (CLK),
    .rst   (RST_SYS),
    .clr   (1'b0),
    .inc   (miss),
    .count (MISS_CNT)
  );

  sat_counter #(
    .WIDTH    (32),
    .SATURATE (1'b0)
  ) u_accept_cnt (
    .clk   (CLK),
    .rst   (RST_SYS),
    .clr   (1'b0),
    .inc   (state_q == S_START),
    .count (ACCEPT_CNT)
  );

  assign DUT_BUSY      = in_idle ? (FIFO_PROG_FULL | ~ENABLE) : 1'b1;
  assign READOUT_START = (state_q == S_START);
  assign TAG_VALID     = (state_q == S_START);
  assign TRIG_TAG      = tag_q;
  assign CNT_TO_FLAG   = cnt_to_q;
  assign RO_TO_FLAG    = ro_to_q;

endmodule

// File: tb/tb_tlu_trigger_ctrl.sv
// Directed bench for tlu_trigger_ctrl with shortened timeouts.
module tb_tlu_trigger_ctrl;

  localparam int CNT_TO = 8;
  localparam int RO_TO  = 32;
  localparam int DEAD   = 4;

  logic        CLK = 1'b0;
  logic        RST_SYS, ENABLE, MODE;
  logic        TRIGGER_VALID, TRIGGER_CNT_VALID;
  logic [15:0] TRIGGER_CNT;
  logic        INT_TRIG, READOUT_DONE, FIFO_PROG_FULL;
  logic        DUT_BUSY, READOUT_START, TAG_VALID;
  logic [15:0] TRIG_TAG, MISS_CNT;
  logic [31:0] ACCEPT_CNT;
  logic        CNT_TO_FLAG, RO_TO_FLAG;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  tlu_trigger_ctrl #(
    .CNT_TIMEOUT (CNT_TO),
    .RO_TIMEOUT  (RO_TO),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .CLK               (CLK),
    .RST_SYS           (RST_SYS),
    .ENABLE            (ENABLE),
    .MODE              (MODE),
    .TRIGGER_VALID     (TRIGGER_VALID),
    .TRIGGER_CNT_VALID (TRIGGER_CNT_VALID),
    .TRIGGER_CNT       (TRIGGER_CNT),
    .INT_TRIG          (INT_TRIG),
    .READOUT_DONE      (READOUT_DONE),
    .FIFO_PROG_FULL    (FIFO_PROG_FULL),
    .DUT_BUSY          (DUT_BUSY),
    .READOUT_START     (READOUT_START),
    .TRIG_TAG          (TRIG_TAG),
    .TAG_VALID         (TAG_VALID),
    .ACCEPT_CNT        (ACCEPT_CNT),
    .MISS_CNT          (MISS_CNT),
    .CNT_TO_FLAG       (CNT_TO_FLAG),
    .RO_TO_FLAG        (RO_TO_FLAG)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!DUT_BUSY) break;
      tick();
    end
    chk(tag, {31'd0, DUT_BUSY}, 32'd0);
  endtask

  task automatic int_pulse();
    INT_TRIG = 1'b1;
    tick();
    INT_TRIG = 1'b0;
  endtask

  initial begin
    int n;
    RST_SYS = 1'b1;
    ENABLE = 1'b1;
    MODE = 1'b0;
    TRIGGER_VALID = 1'b0;
    TRIGGER_CNT_VALID = 1'b0;
    TRIGGER_CNT = 16'h0;
    INT_TRIG = 1'b0;
    READOUT_DONE = 1'b0;
    FIFO_PROG_FULL = 1'b0;
    tick();
    tick();
    RST_SYS = 1'b0;

    // Reset state
    chk("rst_busy", {31'd0, DUT_BUSY}, 32'd0);
    chk("rst_start", {31'd0, READOUT_START}, 32'd0);
    chk("rst_tagv", {31'd0, TAG_VALID}, 32'd0);
    chk("rst_tag", {16'd0, TRIG_TAG}, 32'd0);
    chk("rst_acc", ACCEPT_CNT, 32'd0);
    chk("rst_miss", {16'd0, MISS_CNT}, 32'd0);
    chk("rst_flags", {30'd0, CNT_TO_FLAG, RO_TO_FLAG}, 32'd0);
    ENABLE = 1'b0;
    #1;
    chk("idle_dis_busy", {31'd0, DUT_BUSY}, 32'd1);
    ENABLE = 1'b1;

    // MODE 1: three internal triggers, tags 0,1,2
    MODE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int_pulse();
      chk("m1_start", {31'd0, READOUT_START}, 32'd1);
      chk("m1_tag", {16'd0, TRIG_TAG}, k);
      tick();
      READOUT_DONE = 1'b1;
      tick();
      READOUT_DONE = 1'b0;
      wait_idle("m1_idle");
    end
    chk("m1_acc", ACCEPT_CNT, 32'd3);
    chk("m1_miss", {16'd0, MISS_CNT}, 32'd0);

    // Busy rejection: 4 triggers in READOUT, 1 while FIFO full
    int_pulse();
    chk("rej_start", {31'd0, READOUT_START}, 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      int_pulse();
      chk("rej_no_start", {31'd0, READOUT_START}, 32'd0);
      tick();
    end
    chk("rej_miss4", {16'd0, MISS_CNT}, 32'd4);
    READOUT_DONE = 1'b1;
    tick();
    READOUT_DONE = 1'b0;
    wait_idle("rej_idle");
    FIFO_PROG_FULL = 1'b1;
    #1;
    chk("full_busy", {31'd0, DUT_BUSY}, 32'd1);
    int_pulse();
    chk("full_no_start", {31'd0, READOUT_START}, 32'd0);
    chk("rej_miss5", {16'd0, MISS_CNT}, 32'd5);
    chk("rej_acc", ACCEPT_CNT, 32'd4);
    FIFO_PROG_FULL = 1'b0;
    tick();

    // MODE 0 nominal
    MODE = 1'b0;
    TRIGGER_VALID = 1'b1;
    tick();
    TRIGGER_VALID = 1'b0;
    chk("m0_busy", {31'd0, DUT_BUSY}, 32'd1);
    tick();
    tick();
    tick();
    tick();
    TRIGGER_CNT_VALID = 1'b1;
    TRIGGER_CNT = 16'h1234;
    #1;
    chk("m0_wait", {31'd0, READOUT_START}, 32'd0);
    tick();
    TRIGGER_CNT_VALID = 1'b0;
    TRIGGER_CNT = 16'h0;
    chk("m0_start", {31'd0, READOUT_START}, 32'd1);
    chk("m0_tagv", {31'd0, TAG_VALID}, 32'd1);
    chk("m0_tag", {16'd0, TRIG_TAG}, 32'h1234);
    tick();
    chk("m0_acc", ACCEPT_CNT, 32'd5);
    for (int k = 0; k < 19; k++) tick();
    READOUT_DONE = 1'b1;
    tick();
    READOUT_DONE = 1'b0;
    for (int k = 1; k < DEAD; k++) tick();
    chk("m0_dead_busy", {31'd0, DUT_BUSY}, 32'd1);
    tick();
    chk("m0_busy_fall", {31'd0, DUT_BUSY}, 32'd0);

    // Trigger-number timeout
    TRIGGER_VALID = 1'b1;
    tick();
    TRIGGER_VALID = 1'b0;
    for (int k = 1; k < CNT_TO; k++) tick();
    chk("cto_pre", {31'd0, READOUT_START}, 32'd0);
    chk("cto_flag_pre", {31'd0, CNT_TO_FLAG}, 32'd0);
    tick();
    chk("cto_start", {31'd0, READOUT_START}, 32'd1);
    chk("cto_tag", {16'd0, TRIG_TAG}, 32'hFFFF);
    chk("cto_flag", {31'd0, CNT_TO_FLAG}, 32'd1);
    tick();
    READOUT_DONE = 1'b1;
    tick();
    READOUT_DONE = 1'b0;
    wait_idle("cto_idle");
    chk("cto_acc", ACCEPT_CNT, 32'd6);

    // Readout timeout
    MODE = 1'b1;
    int_pulse();
    chk("rto_tag", {16'd0, TRIG_TAG}, 32'd6);
    tick();
    n = 0;
    while (!RO_TO_FLAG && n < 100) begin
      tick();
      n++;
    end
    chk("rto_cycles", n, RO_TO);
    chk("rto_flag", {31'd0, RO_TO_FLAG}, 32'd1);
    wait_idle("rto_idle");

    // Reset mid-READOUT
    int_pulse();
    tick();
    RST_SYS = 1'b1;
    tick();
    RST_SYS = 1'b0;
    chk("mrst_busy", {31'd0, DUT_BUSY}, 32'd0);
    chk("mrst_acc", ACCEPT_CNT, 32'd0);
    chk("mrst_tag", {16'd0, TRIG_TAG}, 32'd0);
    chk("mrst_flags", {30'd0, CNT_TO_FLAG, RO_TO_FLAG}, 32'd0);
    int_pulse();
    chk("mrst_start", {31'd0, READOUT_START}, 32'd1);
    chk("mrst_tag0", {16'd0, TRIG_TAG}, 32'd0);
    tick();
    chk("mrst_acc1", ACCEPT_CNT, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
